ts_parallel_tx: RTL and testbench



---
 rtl/ts_parallel_tx_if.sv | 23 ++
 rtl/ts_parallel_tx.sv | 181 ++++++++++++++++++
 tb/tb_ts_parallel_tx.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_parallel_tx_if.sv
// Byte-stream input handshake and parallel TS output bus of ts_parallel_tx.
// master: the side feeding bytes and watching the TS bus; slave: the transmitter.
interface ts_parallel_tx_if;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic [7:0] data_out;
    logic       dclk_out;
    logic       d_valid_out;
    logic       p_sync_out;
    logic       sync_err;

    modport master (
        output data_in, in_valid, in_sop,
        input  in_ready, data_out, dclk_out, d_valid_out, p_sync_out, sync_err
    );

    modport slave (
        input  data_in, in_valid, in_sop,
        output in_ready, data_out, dclk_out, d_valid_out, p_sync_out, sync_err
    );
endinterface

// File: rtl/ts_parallel_tx.sv
// Parallel transport-stream transmitter: divides clk into a DCLK byte clock and
// frames fixed-length TS packets with D_VALID / P_SYNC, one byte slot per DCLK.
// Optional: define TS_NULL_PKT_EN to fill idle slots with null packets
// (0x47 0x1F 0xFF 0x10 0xFF...) for a constant-rate stream.
module ts_parallel_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned PKT_LEN   = 188,
    parameter int unsigned GAP_BYTES = 0
) (
    input logic             clk,
    input logic             rst,
    ts_parallel_tx_if.slave bus
);
    localparam int unsigned     DivW     = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf  = DivW'(CLK_DIV / 2);
    localparam logic [7:0]      PktLast  = 8'(PKT_LEN - 1);
    localparam logic [7:0]      GapLast  = 8'(GAP_BYTES - 1);
    localparam logic [7:0]      SyncByte = 8'h47;

`ifdef TS_NULL_PKT_EN
    typedef enum logic [1:0] {StIdle, StPacket, StGap, StNull} state_e;
`else
    typedef enum logic [1:0] {StIdle, StPacket, StGap} state_e;
`endif

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            dclk_q;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            d_valid_q, d_valid_d;
    logic            p_sync_q, p_sync_d;
    logic            sync_err_q, sync_err_d;
    logic            boundary;
    logic            ready;
    logic            accept;

    assign boundary = (div_q == DivLast);
    assign div_d    = boundary ? '0 : div_q + 1'b1;
    assign ready    = boundary && ((state_q == StIdle) || (state_q == StPacket));
    assign accept   = bus.in_valid && ready;

    assign bus.in_ready    = ready;
    assign bus.data_out    = data_q;
    assign bus.dclk_out    = dclk_q;
    assign bus.d_valid_out = d_valid_q;
    assign bus.p_sync_out  = p_sync_q;
    assign bus.sync_err    = sync_err_q;

    // Divider and DCLK: DCLK low for the first half of each slot, so it falls
    // on the same edge that loads a new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            dclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            dclk_q <= (div_d >= DivHalf);
        end
    end

    // Framing state and output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            d_valid_q  <= 1'b0;
            p_sync_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            d_valid_q  <= d_valid_d;
            p_sync_q   <= p_sync_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Next slot contents and framing decisions, evaluated only at slot boundaries.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        d_valid_d  = d_valid_q;
        p_sync_d   = p_sync_q;
        sync_err_d = 1'b0;
        if (boundary) begin
            // Empty slot unless a branch below fills it.
            data_d    = 8'h00;
            d_valid_d = 1'b0;
            p_sync_d  = 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (bus.in_sop) begin
                            if (bus.data_in == SyncByte) begin
                                data_d     = SyncByte;
                                d_valid_d  = 1'b1;
                                p_sync_d   = 1'b1;
                                byte_cnt_d = 8'd1;
                                state_d    = StPacket;
                            end else begin
                                sync_err_d = 1'b1;
                            end
                        end
                    end
`ifdef TS_NULL_PKT_EN
                    else begin
                        data_d     = SyncByte;
                        d_valid_d  = 1'b1;
                        p_sync_d   = 1'b1;
                        byte_cnt_d = 8'd1;
                        state_d    = StNull;
                    end
`endif
                end
                StPacket: begin
                    if (accept) begin
                        if (bus.in_sop) begin
                            // Truncate the running packet; a valid sync byte restarts framing.
                            sync_err_d = 1'b1;
                            if (bus.data_in == SyncByte) begin
                                data_d     = SyncByte;
                                d_valid_d  = 1'b1;
                                p_sync_d   = 1'b1;
                                byte_cnt_d = 8'd1;
                            end else begin
                                byte_cnt_d = '0;
                                state_d    = StIdle;
                            end
                        end else begin
                            data_d    = bus.data_in;
                            d_valid_d = 1'b1;
                            if (byte_cnt_q == PktLast) begin
                                byte_cnt_d = '0;
                                gap_cnt_d  = '0;
                                state_d    = (GAP_BYTES > 0) ? StGap : StIdle;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        gap_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
`ifdef TS_NULL_PKT_EN
                StNull: begin
                    d_valid_d = 1'b1;
                    case (byte_cnt_q)
                        8'd1:    data_d = 8'h1F;
                        8'd2:    data_d = 8'hFF;
                        8'd3:    data_d = 8'h10;
                        default: data_d = 8'hFF;
                    endcase
                    if (byte_cnt_q == PktLast) begin
                        byte_cnt_d = '0;
                        gap_cnt_d  = '0;
                        state_d    = (GAP_BYTES > 0) ? StGap : StIdle;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ts_parallel_tx.sv
// Self-checking bench for ts_parallel_tx: a slot-level model checked every cycle,
// plus literal pins on the recorded slot sequence (run lengths, key bytes, errors).
module tb_ts_parallel_tx;
    localparam int ClkDiv   = 4;
    localparam int PktLen   = 188;
    localparam int GapBytes = 4;
    localparam int LogMax   = 4096;

    typedef struct packed {
        logic       v;
        logic       sop;
        logic [7:0] d;
    } offer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ts_parallel_tx_if bus ();

    ts_parallel_tx #(
        .CLK_DIV  (ClkDiv),
        .PKT_LEN  (PktLen),
        .GAP_BYTES(GapBytes)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    offer_t q[$];

    // Model: phase within slot, bytes of current packet sent, gap slots left,
    // position inside a null packet (0 = none).
    int   phase, pos, gap_left, null_pos;
    int   e_data, e_dv, e_ps, e_err, e_dclk;

    int   lg_data[LogMax];
    int   lg_dv[LogMax];
    int   lg_ps[LogMax];
    int   lg_err[LogMax];
    int   lg_n;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("data_out", int'(bus.data_out), e_data);
        check("d_valid_out", int'(bus.d_valid_out), e_dv);
        check("p_sync_out", int'(bus.p_sync_out), e_ps);
        check("sync_err", int'(bus.sync_err), e_err);
        check("dclk_out", int'(bus.dclk_out), e_dclk);
    endtask

    function automatic int null_byte(input int i);
        case (i)
            0:       return 'h47;
            1:       return 'h1F;
            2:       return 'hFF;
            3:       return 'h10;
            default: return 'hFF;
        endcase
    endfunction

    task automatic push(input logic v, input logic sop, input logic [7:0] d);
        offer_t o;
        o.v   = v;
        o.sop = sop;
        o.d   = d;
        q.push_back(o);
    endtask

    // One clock: drive head offer, predict next cycle, compare, record slot.
    task automatic tick();
        offer_t o;
        bit bnd, rdy, acc;
        o = (q.size() > 0) ? q[0] : '0;
        bus.in_valid = o.v;
        bus.in_sop   = o.sop;
        bus.data_in  = o.d;
        bnd = (phase == ClkDiv - 1);
        rdy = bnd && (gap_left == 0) && (null_pos == 0);
        #1;
        check("in_ready", int'(bus.in_ready), int'(rdy));
        e_err = 0;
        if (bnd) begin
            acc = o.v && rdy;
            if (q.size() > 0 && (!o.v || rdy)) void'(q.pop_front());
            e_data = 0;
            e_dv   = 0;
            e_ps   = 0;
            if (gap_left > 0) begin
                gap_left--;
            end else if (null_pos > 0) begin
                e_dv   = 1;
                e_data = null_byte(null_pos);
                null_pos++;
                if (null_pos == PktLen) begin
                    null_pos = 0;
                    gap_left = GapBytes;
                end
            end else if (acc) begin
                if (o.sop) begin
                    if (pos > 0) e_err = 1;
                    if (o.d == 8'h47) begin
                        e_dv   = 1;
                        e_ps   = 1;
                        e_data = 'h47;
                        pos    = 1;
                    end else begin
                        e_err = 1;
                        pos   = 0;
                    end
                end else if (pos > 0) begin
                    e_dv   = 1;
                    e_data = int'(o.d);
                    pos++;
                    if (pos == PktLen) begin
                        pos      = 0;
                        gap_left = GapBytes;
                    end
                end
            end
`ifdef TS_NULL_PKT_EN
            else if (pos == 0) begin
                e_dv     = 1;
                e_ps     = 1;
                e_data   = 'h47;
                null_pos = 1;
            end
`endif
        end
        phase  = (phase + 1) % ClkDiv;
        e_dclk = (phase >= ClkDiv / 2) ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        if (phase == 0 && lg_n < LogMax) begin
            lg_data[lg_n] = int'(bus.data_out);
            lg_dv[lg_n]   = int'(bus.d_valid_out);
            lg_ps[lg_n]   = int'(bus.p_sync_out);
            lg_err[lg_n]  = int'(bus.sync_err);
            lg_n++;
        end
    endtask

    // Asynchronous reset a little after a falling edge, released on a falling edge.
    task automatic do_reset(input int cycles);
        #2;
        rst = 1'b1;
        q.delete();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.data_in  = 8'h00;
        phase = 0; pos = 0; gap_left = 0; null_pos = 0;
        e_data = 0; e_dv = 0; e_ps = 0; e_err = 0; e_dclk = 0;
        lg_n = 0;
        #1;
        compare_outputs();
        check("rst_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_outputs();
            check("rst_in_ready", int'(bus.in_ready), 0);
        end
        rst = 1'b0;
    endtask

    int exp_n[$];
    int rv[$];
    int rn[$];

    initial begin
        int n, errs, ps_bad, ps_cnt, run_sum, p7_start;
        bit seen_low;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.data_in  = 8'h00;
        @(negedge clk);
        do_reset(3);

        // Partial packet, DCLK timing, then reset mid-packet.
        push(1'b1, 1'b1, 8'h47);
        for (int i = 1; i <= 20; i++) push(1'b1, 1'b0, 8'(i));
        n = 0;
        while (bus.dclk_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("first_dclk_rise_edges", n, ClkDiv / 2);
        n = 0;
        seen_low = 1'b0;
        while (!(seen_low && bus.dclk_out === 1'b1) && n < 20) begin
            tick();
            n++;
            if (bus.dclk_out === 1'b0) seen_low = 1'b1;
        end
        check("dclk_period", n, ClkDiv);
        for (int i = 0; i < 40; i++) tick();
        check("mid_pkt_valid", int'(bus.d_valid_out), 1);
        do_reset(2);

        // Main sequence.
        push(1'b1, 1'b1, 8'h47);
        for (int i = 0; i <= 186; i++) push(1'b1, 1'b0, 8'(i));
        push(1'b1, 1'b1, 8'h47);
        for (int i = 1; i <= 10; i++) push(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'h00);
        for (int i = 11; i <= 187; i++) push(1'b1, 1'b0, 8'(i));
        push(1'b1, 1'b1, 8'h48);
        for (int i = 0; i < 187; i++) push(1'b1, 1'b0, 8'hAA);
        push(1'b1, 1'b1, 8'h47);
        for (int i = 0; i < 187; i++) push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b1, 8'h47);
        for (int i = 1; i <= 99; i++) push(1'b1, 1'b0, 8'(i));
        push(1'b1, 1'b1, 8'h47);
        for (int i = 1; i <= 187; i++) push(1'b1, 1'b0, 8'(i + 128));
        push(1'b1, 1'b1, 8'h47);
        for (int i = 1; i <= 187; i++) push(1'b1, 1'b0, 8'(255 - i));
        for (int i = 0; i < 300; i++) push(1'b0, 1'b0, 8'h00);
        push(1'b1, 1'b1, 8'h47);
        for (int i = 1; i <= 187; i++) push(1'b1, 1'b0, 8'(i) ^ 8'h5A);

        n = 0;
        while (q.size() > 0 && n < 20000) begin
            tick();
            n++;
        end
        check("drain_pending_offers", q.size(), 0);
        for (int i = 0; i < 800; i++) tick();

        // Slot sequence as alternating valid/empty runs.
`ifdef TS_NULL_PKT_EN
        exp_n = '{188, 4, 11, 3, 177, 192, 188, 4, 288, 4, 188, 4, 188, 4, 188, 4, 188};
        p7_start = 1635;
`else
        exp_n = '{188, 4, 11, 3, 177, 192, 188, 4, 288, 4, 188, 300, 188};
        p7_start = 1547;
`endif
        for (int i = 0; i < lg_n; i++) begin
            if (rv.size() == 0 || rv[rv.size() - 1] != lg_dv[i]) begin
                rv.push_back(lg_dv[i]);
                rn.push_back(1);
            end else begin
                rn[rn.size() - 1] = rn[rn.size() - 1] + 1;
            end
        end
        check("first_run_valid", (rv.size() > 0) ? rv[0] : -1, 1);
        run_sum = 0;
        foreach (exp_n[k]) begin
            check($sformatf("run_len[%0d]", k), (k < rn.size()) ? rn[k] : -1, exp_n[k]);
            run_sum += exp_n[k];
        end

        // Pinned bytes and flags.
        check("p2_sync_data", lg_data[0], 'h47);
        check("p2_sync_flag", lg_ps[0], 1);
        check("p2_byte1", lg_data[1], 'h00);
        check("p2_last_byte", lg_data[187], 'hBA);
        check("p2_last_no_sync", lg_ps[187], 0);
        check("p2_after_empty", lg_dv[188], 0);
        check("p3_resume_byte11", lg_data[206], 11);
        check("p4_bad_sop_err", lg_err[387], 1);
        check("p5_restart_err", lg_err[867], 1);
        check("p5_restart_sync", lg_ps[867], 1);
        check("p5_restart_data", lg_data[867], 'h47);
        check("p7_sync_data", lg_data[p7_start], 'h47);
        check("p7_byte1", lg_data[p7_start + 1], 'h5B);
`ifdef TS_NULL_PKT_EN
        check("null_b0", lg_data[1251], 'h47);
        check("null_b1", lg_data[1252], 'h1F);
        check("null_b2", lg_data[1253], 'hFF);
        check("null_b3", lg_data[1254], 'h10);
        check("null_b4", lg_data[1255], 'hFF);
        check("null_last", lg_data[1438], 'hFF);
        check("null_b1_no_sync", lg_ps[1252], 0);
`endif
        errs = 0;
        ps_bad = 0;
        ps_cnt = 0;
        for (int i = 0; i < lg_n; i++) begin
            errs += lg_err[i];
            if (lg_ps[i] == 1 && lg_data[i] != 'h47) ps_bad++;
            if (lg_ps[i] == 1 && lg_dv[i] == 0) ps_bad++;
            if (lg_dv[i] == 0 && lg_data[i] != 0) ps_bad++;
            if (i < run_sum) ps_cnt += lg_ps[i];
        end
        check("sync_err_pulses", errs, 2);
        check("bad_sync_or_empty_slots", ps_bad, 0);
`ifdef TS_NULL_PKT_EN
        check("sync_slot_count", ps_cnt, 9);
`else
        check("sync_slot_count", ps_cnt, 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
